muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It sits directly downstream of the register file. It takes operands from the two register-file read ports (rs on `operandA`, rt on `operandB`). Its `hi`/`lo` outputs feed the writeback mux that drives the register-file write-data port for MFHI/MFLO. While `busy` is high, the control unit stalls any instruction that touches HI/LO.

## Interface
- No parameters; data width is fixed at 32.
- `CLK`  in  1  rising-edge clock.
- `RESETn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch an operation selected by `op`; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `operandA`  in  32  rs value; the multiplicand or dividend.
- `operandB`  in  32  rt value; the multiplier or divisor.
- `writeHi`  in  1  MTHI: load `hi` from `operandA`.
- `writeLo`  in  1  MTLO: load `lo` from `operandA`.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when `hi`/`lo` take a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- **States:**
  - IDLE: normal waiting state.
  - RUN: 32 iterations, driven by a 5-bit counter.
  - FIX: one cycle for sign correction and commit.
- **IDLE → RUN:** on `start`.
  - Latch `op`, the sign flags, and |operandA| and |operandB|.
  - Magnitudes are taken only for the signed ops (01 and 11); unsigned ops latch the raw values.
  - Clear the 64-bit accumulator/remainder and set the counter to 0.
- **RUN:** one iteration per cycle.
  - Multiply: shift-add, 1 multiplier bit per cycle.
  - Divide: restoring division, 1 quotient bit per cycle.
  - RUN → FIX when the counter reaches 31.
- **FIX:**
  - MULT: negate the 64-bit product if signA≠signB; hi = product[63:32], lo = product[31:0].
  - DIV: lo = quotient, negated if signA≠signB; hi = remainder, negated if signA=1.
  - Write hi/lo, pulse `done`, then go to IDLE.
- **Divide by zero** (operandB = 0, any DIV op): still takes the full latency; result is lo = 32'hFFFFFFFF, hi = the raw latched operandA.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This falls out of the magnitude arithmetic; no special case.
- **MTHI/MTLO:** act only in IDLE with `start` low.
  - Take effect at the next edge.
  - `writeHi` and `writeLo` together load both registers from `operandA`.
- **Ignored inputs:**
  - `start`, `writeHi` and `writeLo` are ignored while `busy` is high.
  - If `start` and a write coincide in IDLE, `start` wins and the write is dropped.
- `hi`/`lo` change only on FIX commit, an MTHI/MTLO write, or reset.

## Timing
- **Reset:** `RESETn` low immediately forces:
  - state IDLE, `busy` = 0, `done` = 0;
  - `hi` = 0, `lo` = 0, counter = 0.
- **Reset mid-operation:** aborts the operation with no commit; the unit is ready for `start` on the first edge after `RESETn` returns high.
- **Latency:** with `start` sampled at edge E0:
  - `busy` = 1 from after E0 until after E33.
  - RUN occupies edges E1–E32; FIX commits at E33.
  - After E33, `hi`/`lo` hold the result, `done` = 1 for exactly one cycle, and `busy` = 0.
  - Total is 33 cycles from `start` to result visible.
- **Back-to-back:** `start` may be reasserted in the `done` cycle (state is IDLE) and is accepted at that edge.
- **Outputs:** `busy`, `done`, `hi` and `lo` are all registered; there is no combinational path from inputs to outputs.
- **Operands:** only needed at the `start` edge; later changes on `operandA`/`operandB` do not affect the operation.

## Test plan
- **Reset and MTHI/MTLO:** reset → hi = lo = 0, busy = 0. Then writeHi with operandA = 0x12345678 → hi = 0x12345678, lo unchanged; writeLo with 0xCAFEBABE → lo = 0xCAFEBABE.
- **MULTU and MULT:**
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001, done exactly 33 cycles after start.
  - MULT 0xFFFFFFFF (−1) × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF9.
- **DIV and DIVU:**
  - DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU 100 / 7 → lo = 14, hi = 2.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero:** DIVU 0x55 / 0 → lo = 0xFFFFFFFF, hi = 0x55, after the same 33-cycle latency.
- **Ignored while busy:** start a MULT, then pulse start, writeHi and writeLo while busy → no effect; the original result commits. Assert start and writeLo together in IDLE → lo takes the operation result only.
- **Reset mid-RUN:** pull RESETn low at cycle 10 → busy = 0, hi = lo = 0 immediately, no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide with HI/LO; result visible 33 cycles after start.
// No backpressure: start/MTHI/MTLO are simply ignored while busy.
module muldiv_unit (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic        writeHi,
   input  logic        writeLo,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [32:0] rem_sh;
   logic [32:0] rem_sub;
   logic [32:0] sum;
   logic [63:0] prod;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      rem_sh   = '0;
      rem_sub  = '0;
      sum      = '0;
      prod     = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_div_d = op[1];
               sign_a_d = op[0] & operandA[31];
               sign_b_d = op[0] & operandB[31];
               a_d      = (op[0] & operandA[31]) ? -operandA : operandA;
               b_d      = (op[0] & operandB[31]) ? -operandB : operandB;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end else begin
               if (writeHi) hi_d = operandA;
               if (writeLo) lo_d = operandA;
            end
         end
         S_RUN: begin
            if (is_div_q) begin
               // acc holds {remainder, quotient}; dividend bits enter MSB first
               rem_sh  = {acc_q[63:32], a_q[~cnt_q]};
               rem_sub = rem_sh - {1'b0, b_q};
               if (rem_sh >= {1'b0, b_q})
                  acc_d = {rem_sub[31:0], acc_q[30:0], 1'b1};
               else
                  acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end else begin
               sum   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
               acc_d = {sum, acc_q[31:1]};
               b_d   = {1'b0, b_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               if (b_q == 32'd0) begin
                  // a_q holds |A|; re-applying the sign recovers the raw dividend
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = sign_a_q ? -a_q : a_q;
               end else begin
                  lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
                  hi_d = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
               end
            end else begin
               prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
               hi_d = prod[63:32];
               lo_d = prod[31:0];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_FIX);
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random/directed bench for muldiv_unit against a plain-arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_muldiv_unit;

   logic        CLK;
   logic        RESETn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        writeHi;
   logic        writeLo;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   muldiv_unit dut (
      .CLK(CLK), .RESETn(RESETn), .start(start), .op(op),
      .operandA(operandA), .operandB(operandB),
      .writeHi(writeHi), .writeLo(writeLo),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] cyc = '0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   always @(posedge CLK) cyc <= cyc + 32'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: {hi, lo} straight from integer arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic signed [31:0] sa, sb, q, r;
      logic [63:0]        p;
      sa = a;
      sb = b;
      p  = '0;
      case (o)
         2'b00: p = {32'd0, a} * {32'd0, b};
         2'b01: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            p  = sp;
         end
         2'b10: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 32'd0)
               p = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               p = {32'd0, 32'h8000_0000};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r, q};
            end
         end
      endcase
      return p;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom_range(0, 255);
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge CLK) begin
      exp_t e;
      if (done) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1, expected no outstanding op");
         end else begin
            e = sb_q.pop_front();
            chk("result_hi", hi, e.hi);
            chk("result_lo", lo, e.lo);
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic push_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] m;
      m      = model(o, a, b);
      e.hi   = m[63:32];
      e.lo   = m[31:0];
      e.cyc  = cyc + 32'd34;
      exp_hi = m[63:32];
      exp_lo = m[31:0];
      sb_q.push_back(e);
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL done_timeout: got no done in 40 cycles, expected done");
      end
      chk("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   // Called just after a negedge; the start edge is the next posedge
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic wh, input logic wl);
      start    = 1'b1;
      op       = o;
      operandA = a;
      operandB = b;
      writeHi  = wh;
      writeLo  = wl;
      push_op(o, a, b);
      @(negedge CLK);
      start    = 1'b0;
      writeHi  = 1'b0;
      writeLo  = 1'b0;
      operandA = $urandom;
      operandB = $urandom;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      wait_done();
   endtask

   initial begin
      logic [31:0] pre_hi, pre_lo;
      RESETn   = 1'b0;
      start    = 1'b0;
      op       = 2'b00;
      operandA = '0;
      operandB = '0;
      writeHi  = 1'b0;
      writeLo  = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      RESETn = 1'b1;
      @(negedge CLK);

      writeHi  = 1'b1;
      operandA = 32'h1234_5678;
      @(negedge CLK);
      writeHi  = 1'b0;
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_lo", lo, 32'd0);
      writeLo  = 1'b1;
      operandA = 32'hCAFE_BABE;
      @(negedge CLK);
      writeLo  = 1'b0;
      chk("mtlo_lo", lo, 32'hCAFE_BABE);
      chk("mtlo_hi", hi, 32'h1234_5678);
      writeHi  = 1'b1;
      writeLo  = 1'b1;
      operandA = 32'h0BAD_F00D;
      @(negedge CLK);
      writeHi  = 1'b0;
      writeLo  = 1'b0;
      chk("mt_both_hi", hi, 32'h0BAD_F00D);
      chk("mt_both_lo", lo, 32'h0BAD_F00D);

      // Directed ops, issued back-to-back in each done cycle
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);
      do_op(2'b01, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b0);
      chk("mult_lo", lo, 32'hFFFF_FFF9);
      do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      do_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'd0);
      do_op(2'b10, 32'h55, 32'd0, 1'b0, 1'b0);
      chk("divz_lo", lo, 32'hFFFF_FFFF);
      chk("divz_hi", hi, 32'h55);
      do_op(2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
      chk("divz_neg_hi", hi, 32'hFFFF_FFFB);

      // start and MTLO together: start wins
      do_op(2'b10, 32'd1000, 32'd9, 1'b0, 1'b1);
      chk("start_wins_lo", lo, 32'd111);

      // Start, then disturb while busy
      pre_hi   = hi;
      pre_lo   = lo;
      start    = 1'b1;
      op       = 2'b01;
      operandA = 32'hFFFF_FC18;
      operandB = 32'd12345;
      push_op(2'b01, 32'hFFFF_FC18, 32'd12345);
      @(negedge CLK);
      start    = 1'b0;
      repeat (5) @(negedge CLK);
      start    = 1'b1;
      op       = 2'b10;
      writeHi  = 1'b1;
      writeLo  = 1'b1;
      operandA = 32'hDEAD_BEEF;
      @(negedge CLK);
      start    = 1'b0;
      writeHi  = 1'b0;
      writeLo  = 1'b0;
      chk("busy_ign_hi", hi, pre_hi);
      chk("busy_ign_lo", lo, pre_lo);
      wait_done();

      for (int k = 0; k < 24; k++) begin
         logic [1:0] ro;
         ro = 2'($urandom_range(0, 3));
         do_op(ro, pick(), pick(), 1'b0, 1'b0);
      end

      // Reset in the middle of RUN
      start    = 1'b1;
      op       = 2'b00;
      operandA = 32'h1357_9BDF;
      operandB = 32'h2468_ACE0;
      @(negedge CLK);
      start    = 1'b0;
      repeat (9) @(negedge CLK);
      RESETn = 1'b0;
      sb_q.delete();
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      do_op(2'b11, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
      chk("post_rst_lo", lo, 32'hFFFF_FFF2);
      chk("post_rst_hi", hi, 32'hFFFF_FFFE);

      repeat (40) @(negedge CLK);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end of test, expected completion");
      $fatal(1, "timeout");
   end

endmodule
